// File: rtl/seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seq_decoder
// Purpose  : Registered multi-cycle instruction decoder. Owns the PC, the
//            fetch handshake, call-depth tracking and the halt state. Flags
//            stack over/underflow and undefined opcodes as sticky errors.
// Options  : SEQ_DECODER_BRTRACE_EN adds the br_taken_cnt output, a
//            saturating count of EXEC cycles that broke sequential flow.
// Revision : 1.0 - initial release
// ============================================================================
module seq_decoder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               instr_valid,
  input  logic [DATA_W-1:0]                  instr,
  input  logic [DATA_W-1:0]                  N,
  input  logic                               jump,
  input  logic [DATA_W-1:0]                  rddata,
  input  logic [DATA_W-1:0]                  rsdata,
  input  logic                               resume,
  output logic                               instr_ready,
  output logic [ADDR_W-1:0]                  pc,
  output logic [ADDR_W-1:0]                  instr_addr1,
  output logic [ADDR_W-1:0]                  instr_addr2,
  output logic [ADDR_W-1:0]                  new_pc,
  output logic [2:0]                         giantmux_sel,
  output logic                               rd_wen,
  output logic                               rs_wen,
  output logic                               push_up,
  output logic                               move_fp,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   call_depth,
  output logic                               halted,
  output logic                               stack_err,
  output logic                               illegal
`ifdef SEQ_DECODER_BRTRACE_EN
  ,
  output logic [15:0]                        br_taken_cnt
`endif
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   r_n;
  logic [ADDR_W-1:0]   r_pc;
  logic [DEPTH_W-1:0]  r_depth;
  logic                r_stack_err;
  logic                r_illegal;

  logic [4:0]          w_op;
  logic                w_imm;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_pc_seq;
  logic [ADDR_W-1:0]   w_new_pc;
  logic                w_depth_inc;
  logic                w_depth_dec;
  logic                w_stack_halt;
  logic                w_ill_halt;
  logic                w_stp;
  logic                w_branch;
  logic                w_unused_bits;

  // Only the opcode field and a few operand bits steer control; the Rs read
  // port is wired through for future use.
  assign w_unused_bits = ^{rsdata, r_instr};

  assign w_op     = r_instr[15:11];
  assign w_imm    = r_instr[11];
  assign w_accept = (r_state == ST_FETCH) && instr_valid;
  // Sequential successor: skips the immediate word of two-word instructions.
  assign w_pc_seq = r_pc + ADDR_W'(1) + ADDR_W'(w_imm);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next state, control strobes and next-PC selection
  always_comb begin
    w_state_nxt  = r_state;
    w_new_pc     = r_pc;
    rd_wen       = 1'b0;
    rs_wen       = 1'b0;
    push_up      = 1'b0;
    move_fp      = 1'b0;
    giantmux_sel = 3'b000;
    w_depth_inc  = 1'b0;
    w_depth_dec  = 1'b0;
    w_stack_halt = 1'b0;
    w_ill_halt   = 1'b0;
    w_stp        = 1'b0;
    w_branch     = 1'b0;
    case (r_state)
      ST_FETCH: if (instr_valid) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_new_pc = w_pc_seq;
        casez (w_op)
          5'b00000: ;
          5'b00001: begin
            if (r_depth < DEPTH_W'(STACK_DEPTH)) begin
              push_up      = 1'b1;
              rd_wen       = 1'b1;
              giantmux_sel = 3'b001;
              w_new_pc     = ADDR_W'(r_n);
              w_depth_inc  = 1'b1;
              w_branch     = 1'b1;
            end else begin
              w_stack_halt = 1'b1;
              w_new_pc     = r_pc;
            end
          end
          5'b11100: begin
            if (r_depth != '0) begin
              move_fp     = 1'b1;
              w_new_pc    = ADDR_W'(rddata);
              w_depth_dec = 1'b1;
              w_branch    = 1'b1;
            end else begin
              w_stack_halt = 1'b1;
              w_new_pc     = r_pc;
            end
          end
          5'b00100: begin
            w_new_pc = ADDR_W'(rddata);
            w_branch = 1'b1;
          end
          5'b00101: begin
            w_new_pc = ADDR_W'(r_n);
            w_branch = 1'b1;
          end
          5'b0001?: begin
            if (jump) begin
              w_new_pc = w_pc_seq + ADDR_W'(r_instr[1:0]);
              w_branch = 1'b1;
            end
          end
          5'b010??: begin
            rd_wen       = 1'b1;
            giantmux_sel = 3'b100;
            // SUB with skip enabled hops over the following instruction.
            if (w_op[1] && r_instr[2] && jump) begin
              w_new_pc = r_pc + ADDR_W'(2) + ADDR_W'(w_imm) + ADDR_W'(r_instr[0]);
              w_branch = 1'b1;
            end
          end
          5'b110?0: begin
            rd_wen       = 1'b1;
            giantmux_sel = 3'b100;
          end
          5'b0110?: begin
            rd_wen       = 1'b1;
            giantmux_sel = 3'b101;
          end
          5'b0111?: begin
            rd_wen       = 1'b1;
            giantmux_sel = {1'b0, w_imm, 1'b0};
          end
          5'b11111: begin
            w_stp    = 1'b1;
            w_new_pc = r_pc;
          end
          default: begin
            w_ill_halt = 1'b1;
            w_new_pc   = r_pc;
          end
        endcase
        w_state_nxt = (w_stack_halt || w_ill_halt || w_stp) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: if (resume) w_state_nxt = ST_FETCH;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Capture opcode and immediate words on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_n     <= '0;
    end else if (w_accept) begin
      r_instr <= instr;
      r_n     <= N;
    end
  end

  // PC, call depth and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= '0;
      r_depth     <= '0;
      r_stack_err <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_pc <= w_new_pc;
      if (w_depth_inc) r_depth <= r_depth + DEPTH_W'(1);
      if (w_depth_dec) r_depth <= r_depth - DEPTH_W'(1);
      if (w_stack_halt) r_stack_err <= 1'b1;
      if (w_ill_halt)   r_illegal   <= 1'b1;
    end else if (r_state == ST_HALT && resume) begin
      r_pc        <= r_pc + ADDR_W'(1);
      r_stack_err <= 1'b0;
      r_illegal   <= 1'b0;
    end
  end

`ifdef SEQ_DECODER_BRTRACE_EN
  logic [15:0] r_br_cnt;

  // Saturating count of executed control-flow discontinuities
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_br_cnt <= '0;
    else if (r_state == ST_EXEC && w_branch && r_br_cnt != 16'hFFFF)
      r_br_cnt <= r_br_cnt + 16'd1;
  end

  assign br_taken_cnt = r_br_cnt;
`endif

  assign instr_ready = (r_state == ST_FETCH);
  assign halted      = (r_state == ST_HALT);
  assign pc          = r_pc;
  assign instr_addr1 = r_pc;
  assign instr_addr2 = r_pc + ADDR_W'(1);
  assign new_pc      = w_new_pc;
  assign call_depth  = r_depth;
  assign stack_err   = r_stack_err;
  assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
- Registered, multi-cycle successor to the combinational instruction decoder; owns the PC, fetch handshake, call-depth tracking and halt state.
- Sits between dual-port instruction memory (port 1 = opcode word, port 2 = immediate word N) and the register file/ALU/giant mux.
- Parametrised in data/address width and call-stack depth; detects stack over/underflow and illegal opcodes, which the old decoder silently mapped to STP.

Parameters:
DATA_W, 16, width of instruction words, N, rddata, rsdata
ADDR_W, 16, width of PC and all memory addresses
STACK_DEPTH, 16, maximum nested CALL depth (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction memory has returned words for the addresses presented
instr  in  DATA_W  opcode word read at instr_addr1
N  in  DATA_W  immediate word read at instr_addr2
jump  in  1  condition flag from ALU, sampled in EXEC
rddata  in  DATA_W  Rd register read data
rsdata  in  DATA_W  Rs register read data
resume  in  1  leave HALT (single-cycle pulse)
instr_ready  out  1  decoder accepting instruction (high in FETCH only)
pc  out  ADDR_W  current program counter
instr_addr1  out  ADDR_W  = pc
instr_addr2  out  ADDR_W  = pc+1 (mod 2^ADDR_W)
new_pc  out  ADDR_W  PC value loaded at end of EXEC
giantmux_sel  out  3  write-back source select
rd_wen, rs_wen, push_up, move_fp  out  1 each  single-cycle control strobes
call_depth  out  clog2(STACK_DEPTH+1)  current nesting depth
halted  out  1  FSM in HALT
stack_err  out  1  sticky: overflow/underflow caused halt
illegal  out  1  sticky: undefined opcode caused halt

Behaviour:
- Reset (async): state=FETCH, pc=0, call_depth=0, all strobes/flags 0, giantmux_sel=000, new_pc=0.
- FSM: FETCH -> EXEC when instr_valid & instr_ready (instr and N registered on that edge); EXEC -> FETCH after exactly 1 cycle unless halting; HALT -> FETCH on resume (pc<=pc+1, stack_err/illegal cleared); resume outside HALT ignored.
- Latency: strobes assert only in EXEC, one cycle after acceptance; 2 cycles minimum per instruction.
- op = instr[15:11]; instr[11] = immediate flag (two-word instr); default next pc = pc+1+instr[11].
- 00000 NOP: no strobes.
- 00001 CALL: depth<STACK_DEPTH -> push_up=1, rd_wen=1, giantmux_sel=001, pc<=N, depth+1; else stack_err=1, HALT, pc unchanged.
- 11100 RTN: depth>0 -> move_fp=1, push_up=0, pc<=rddata, depth-1; else stack_err, HALT.
- 00100 JMP R: pc<=rddata. 00101 JMP I: pc<=N.
- 0001x CMP: jump=1 -> pc<=pc+1+instr[11]+instr[1:0]; else default.
- 0100x/0101x ADD/SUB, 110x0 LSL/LSR: rd_wen=1, giantmux_sel=100. SUB with instr[2]=1 and jump=1: pc<=pc+2+instr[11]+instr[0].
- 0110x MAS: rd_wen=1, sel=101. 0111x MOV: rd_wen=1, sel={0,instr[11],0}.
- 11111 STP: HALT, pc stays at STP address.
- Any other op: illegal=1, HALT.
- new_pc valid in EXEC; pc<=new_pc on EXEC exit. All PC arithmetic mod 2^ADDR_W (0xFFFF+1 -> 0x0000).
- instr_valid while not in FETCH ignored. Reset mid-EXEC aborts with no write strobe completing.

Optional Feature:
- SEQ_DECODER_BRTRACE_EN defined: extra output br_taken_cnt (16 bits), +1 each EXEC with a PC discontinuity (CALL, RTN, JMP, taken CMP/SUB skip), saturates at 0xFFFF, cleared by reset only.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset then NOP at 0 with instr_valid held -> EXEC at cycle 2, pc=1 at cycle 3, no strobes.
- CALL N=0x0040 at pc=5 -> push_up, rd_wen, sel=001 for 1 cycle; pc=0x0040, call_depth=1; RTN rddata=0x0007 -> pc=0x0007, depth=0.
- STACK_DEPTH=2, three nested CALLs -> third raises stack_err, halted=1, pc at third CALL; resume -> pc+1, flags cleared.
- CMP instr[11]=1, instr[1:0]=2, jump=1 at pc=0x10 -> pc=0x14; jump=0 -> pc=0x12.
- pc=0xFFFF, NOP -> pc=0x0000; op 10101 -> illegal=1, HALT.
- Assert reset during EXEC of ADD -> rd_wen drops immediately, pc=0, state FETCH.
